// File: rtl/generic_fifo_occ.sv
// Valid/grant FIFO with any depth, occupancy count, almost-full/empty flags and flush.
// Define GENERIC_FIFO_BYPASS_EN for fall-through (zero first-word latency) when empty.
module generic_fifo_occ #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8,
  parameter int AF_THRESH  = DATA_DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            FLUSH_IN,
  input  logic [DATA_WIDTH-1:0]           DATA_IN,
  input  logic                            VALID_IN,
  output logic                            GRANT_OUT,
  output logic [DATA_WIDTH-1:0]           DATA_OUT,
  output logic                            VALID_OUT,
  input  logic                            GRANT_IN,
  output logic [$clog2(DATA_DEPTH+1)-1:0] USAGE_OUT,
  output logic                            ALMOST_FULL_OUT,
  output logic                            ALMOST_EMPTY_OUT
);

  localparam int PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CNT_W = $clog2(DATA_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PTR_W-1:0]      push_ptr;
  logic [PTR_W-1:0]      pop_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  pass;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_comb begin
    GRANT_OUT = ~full;
`ifdef GENERIC_FIFO_BYPASS_EN
    // Empty and not flushing: the input word is presented directly at the head.
    if (empty && !FLUSH_IN) begin
      VALID_OUT = VALID_IN;
      DATA_OUT  = DATA_IN;
    end else begin
      VALID_OUT = ~empty;
      DATA_OUT  = mem[pop_ptr];
    end
    pass = empty & ~FLUSH_IN & VALID_IN & GRANT_IN;
`else
    VALID_OUT = ~empty;
    DATA_OUT  = mem[pop_ptr];
    pass      = 1'b0;
`endif
    push = VALID_IN & ~full & ~pass;
    pop  = ~empty & GRANT_IN;
  end

  assign USAGE_OUT        = count;
  assign ALMOST_FULL_OUT  = (count >= AF_CNT);
  assign ALMOST_EMPTY_OUT = (count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      push_ptr <= '0;
      pop_ptr  <= '0;
      count    <= '0;
      for (int i = 0; i < DATA_DEPTH; i++) mem[i] <= '0;
    end else if (FLUSH_IN) begin
      // Storage keeps stale words; only the bookkeeping is cleared.
      push_ptr <= '0;
      pop_ptr  <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[push_ptr] <= DATA_IN;
        push_ptr      <= next_ptr(push_ptr);
      end
      if (pop) pop_ptr <= next_ptr(pop_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
